// File: rtl/cmd_seq_pkg.sv
// ---------------------------------------------------------------------------
// cmd_seq_pkg
// Shared types and constants for the KnightsTour host-side command sequencer.
//   state_t      : sequencer FSM states (also exported on the debug port)
//   ACK_BYTE     : positive acknowledge byte returned by remoteComm
//   ERR_*        : err_code encodings
//   CMD_*        : KnightsTour command opcodes (full word or upper nibble)
// ---------------------------------------------------------------------------
package cmd_seq_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ISSUE     = 3'd1,
      WAIT_SENT = 3'd2,
      WAIT_RESP = 3'd3,
      DONE      = 3'd4,
      ERR       = 3'd5
   } state_t;

   localparam logic [7:0]  ACK_BYTE    = 8'hA5;

   localparam logic [1:0]  ERR_NONE    = 2'b00;
   localparam logic [1:0]  ERR_TIMEOUT = 2'b01;
   localparam logic [1:0]  ERR_BADRESP = 2'b10;

   localparam logic [15:0] CMD_CAL     = 16'h2000;
   localparam logic [3:0]  CMD_MOVE    = 4'h4;
   localparam logic [3:0]  CMD_TOUR    = 4'h6;

   // Saturating 8-bit increment used for the pass counter.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/cmd_fifo.sv
// ---------------------------------------------------------------------------
// cmd_fifo
// Synchronous first-word-fall-through FIFO holding queued 16-bit commands.
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_flush      : discard all entries (wins over push/pop)
//   i_push       : write i_wr_data when not full (dropped when full, even if
//                  a pop happens in the same cycle)
//   i_pop        : discard the head entry when not empty
//   i_wr_data    : data to enqueue
//   o_rd_data    : current head entry (valid when !o_empty)
//   o_full       : DEPTH entries held
//   o_empty      : no entries held
// ---------------------------------------------------------------------------
module cmd_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_flush,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_wr_data,
   output logic [WIDTH-1:0] o_rd_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int          AW       = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == FULL_CNT);
   assign o_empty   = (r_count == '0);
   assign o_rd_data = r_mem[r_rd_ptr];

   assign w_do_push = i_push && !o_full  && !i_flush;
   assign w_do_pop  = i_pop  && !o_empty && !i_flush;

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_wr_data;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/cmd_sequencer.sv
// ---------------------------------------------------------------------------
// cmd_sequencer
// Host-side KnightsTour command scheduler. Queues 16-bit commands and issues
// them one at a time to remoteComm; each must be sent and acknowledged with
// 0xA5 before the next goes out.
//
// Handshake: send_cmd is a one-cycle request with cmd valid in that cycle and
// held until the next request. cmd_sent is a level meaning both bytes left.
// A response is taken only on a rising edge of resp_rdy (previous value
// registered); a level left high from an earlier response is never counted.
//
// Build option: define CMD_SEQ_TIMEOUT_EN to build the per-command timeout
// (err_code 01 after TIMEOUT_CYC cycles from ISSUE). Without it the wait
// states block indefinitely and TIMEOUT_CYC is unused.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   cmd_in, push        : enqueue a command (dropped when full or in ERR)
//   start               : begin draining the queue (honoured in IDLE only)
//   abort               : go IDLE, flush queue, clear error (top priority)
//   full, empty         : queue status
//   cmd, send_cmd       : command and one-cycle request to remoteComm
//   cmd_sent, resp_rdy,
//   resp                : remoteComm status and response byte
//   busy, done          : sequencing in progress / one-cycle completion pulse
//   err, err_code,
//   bad_resp            : sticky error, its cause, offending response byte
//   pass_cnt            : acked commands since start (saturating)
//   dbg_state           : current FSM state
// ---------------------------------------------------------------------------
module cmd_sequencer
   import cmd_seq_pkg::*;
#(
   parameter int DEPTH       = 8,
   parameter int TIMEOUT_CYC = 80_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] cmd_in,
   input  logic        push,
   input  logic        start,
   input  logic        abort,
   output logic        full,
   output logic        empty,
   output logic [15:0] cmd,
   output logic        send_cmd,
   input  logic        cmd_sent,
   input  logic        resp_rdy,
   input  logic [7:0]  resp,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [1:0]  err_code,
   output logic [7:0]  bad_resp,
   output logic [7:0]  pass_cnt,
   output state_t      dbg_state
);

   state_t      r_state;
   logic [15:0] r_cmd;
   logic        r_send_cmd;
   logic        r_busy;
   logic        r_done;
   logic        r_err;
   logic [1:0]  r_err_code;
   logic [7:0]  r_bad_resp;
   logic [7:0]  r_pass_cnt;
   logic        r_resp_rdy_q;

   logic [15:0] w_head;
   logic        w_full;
   logic        w_empty;
   logic        w_push;
   logic        w_pop;
   logic        w_resp_rise;
   logic        w_tmo_hit;

   // Queue is frozen in ERR so the unsent commands remain for inspection.
   assign w_push = push && (r_state != ERR);
   assign w_pop  = (r_state == ISSUE);

   cmd_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (16)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_flush   (abort),
      .i_push    (w_push),
      .i_pop     (w_pop),
      .i_wr_data (cmd_in),
      .o_rd_data (w_head),
      .o_full    (w_full),
      .o_empty   (w_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_resp_rdy_q <= 1'b0;
      else        r_resp_rdy_q <= resp_rdy;
   end

   assign w_resp_rise = resp_rdy && !r_resp_rdy_q;

`ifdef CMD_SEQ_TIMEOUT_EN
   localparam int          TW       = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

   logic [TW-1:0] r_tmo_cnt;

   // Holds the number of cycles elapsed since the ISSUE cycle: ISSUE loads 1
   // so the first wait cycle reads 1, and the limit is hit in the cycle that
   // reads TIMEOUT_CYC-1, putting ERR exactly TIMEOUT_CYC cycles after ISSUE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tmo_cnt <= '0;
      end else if (r_state == ISSUE) begin
         r_tmo_cnt <= TW'(1);
      end else if ((r_state == WAIT_SENT) || (r_state == WAIT_RESP)) begin
         r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end else begin
         r_tmo_cnt <= '0;
      end
   end

   assign w_tmo_hit = (r_tmo_cnt == TMO_LAST);
`else
   logic w_unused_tmo_cfg;
   assign w_unused_tmo_cfg = (TIMEOUT_CYC > 0);
   assign w_tmo_hit        = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_cmd      <= '0;
         r_send_cmd <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_err_code <= ERR_NONE;
         r_bad_resp <= '0;
         r_pass_cnt <= '0;
      end else if (abort) begin
         // pass_cnt is deliberately left alone so the host can read progress.
         r_state    <= IDLE;
         r_send_cmd <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_err_code <= ERR_NONE;
         r_bad_resp <= '0;
      end else begin
         r_send_cmd <= 1'b0;
         r_done     <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start && !w_empty) begin
                  r_state    <= ISSUE;
                  r_cmd      <= w_head;
                  r_send_cmd <= 1'b1;
                  r_busy     <= 1'b1;
                  r_pass_cnt <= '0;
               end
            end
            ISSUE: begin
               r_state <= WAIT_SENT;
            end
            WAIT_SENT: begin
               if (w_tmo_hit) begin
                  r_state    <= ERR;
                  r_busy     <= 1'b0;
                  r_err      <= 1'b1;
                  r_err_code <= ERR_TIMEOUT;
               end else if (cmd_sent) begin
                  r_state <= WAIT_RESP;
               end
            end
            WAIT_RESP: begin
               // An ack arriving in the limit cycle takes precedence.
               if (w_resp_rise) begin
                  if (resp == ACK_BYTE) begin
                     r_pass_cnt <= sat_inc8(r_pass_cnt);
                     if (!w_empty) begin
                        r_state    <= ISSUE;
                        r_cmd      <= w_head;
                        r_send_cmd <= 1'b1;
                     end else begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                     end
                  end else begin
                     r_state    <= ERR;
                     r_busy     <= 1'b0;
                     r_err      <= 1'b1;
                     r_err_code <= ERR_BADRESP;
                     r_bad_resp <= resp;
                  end
               end else if (w_tmo_hit) begin
                  r_state    <= ERR;
                  r_busy     <= 1'b0;
                  r_err      <= 1'b1;
                  r_err_code <= ERR_TIMEOUT;
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
            ERR: begin
               r_state <= ERR;
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign full      = w_full;
   assign empty     = w_empty;
   assign cmd       = r_cmd;
   assign send_cmd  = r_send_cmd;
   assign busy      = r_busy;
   assign done      = r_done;
   assign err       = r_err;
   assign err_code  = r_err_code;
   assign bad_resp  = r_bad_resp;
   assign pass_cnt  = r_pass_cnt;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cmd_sequencer
// Directed bench for cmd_sequencer. Commands expected on the remoteComm side
// are queued in exp_q when pushed and checked in order as send_cmd pulses
// appear. The remoteComm side is modelled by serve_one.
// ---------------------------------------------------------------------------
module tb_cmd_sequencer;
   import cmd_seq_pkg::*;

   localparam int DEPTH = 8;
   localparam int TMO   = 1000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] cmd_in = '0;
   logic        push = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        full;
   logic        empty;
   logic [15:0] cmd;
   logic        send_cmd;
   logic        cmd_sent = 1'b0;
   logic        resp_rdy = 1'b0;
   logic [7:0]  resp = '0;
   logic        busy;
   logic        done;
   logic        err;
   logic [1:0]  err_code;
   logic [7:0]  bad_resp;
   logic [7:0]  pass_cnt;
   state_t      dbg_state;

   logic [15:0] exp_q[$];
   int          n_vec = 0;
   int          n_err = 0;

   cmd_sequencer #(
      .DEPTH       (DEPTH),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_in    (cmd_in),
      .push      (push),
      .start     (start),
      .abort     (abort),
      .full      (full),
      .empty     (empty),
      .cmd       (cmd),
      .send_cmd  (send_cmd),
      .cmd_sent  (cmd_sent),
      .resp_rdy  (resp_rdy),
      .resp      (resp),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .err_code  (err_code),
      .bad_resp  (bad_resp),
      .pass_cnt  (pass_cnt),
      .dbg_state (dbg_state)
   );

   // ---- clock / watchdog ---------------------------------------------------
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // ---- driver tasks -------------------------------------------------------
   // Advance to 1 ns after the next rising edge; push is a one-cycle strobe.
   task automatic tick();
      @(posedge clk);
      #1;
      push = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic push_cmd(input logic [15:0] c, input bit expect_issue);
      cmd_in = c;
      push   = 1'b1;
      tick();
      if (expect_issue) exp_q.push_back(c);
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Called at the sample point of an expected ISSUE cycle. Checks the
   // request, raises cmd_sent, then delivers response r on a fresh rise of
   // resp_rdy. Returns at the sample point one cycle after the response.
   task automatic serve_one(input logic [7:0] r, input bit hold);
      logic [15:0] e;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
      chk("send_cmd_pulse", send_cmd, 1);
      chk("cmd_order", cmd, e);
      tick();
      chk("send_cmd_single", send_cmd, 0);
      cmd_sent = 1'b1;
      tick();
      cmd_sent = 1'b0;
      if (resp_rdy) begin
         repeat (3) begin
            tick();
            chk("stale_level_ignored", dbg_state, WAIT_RESP);
         end
         resp_rdy = 1'b0;
         tick();
      end
      resp     = r;
      resp_rdy = 1'b1;
      tick();
      if (!hold) resp_rdy = 1'b0;
   endtask

   // ---- directed sequence --------------------------------------------------
   initial begin
      logic [15:0] e;
      logic [15:0] five [5];
      five[0] = CMD_CAL;
      five[1] = 16'h4001;
      five[2] = 16'h43F1;
      five[3] = 16'h47F1;
      five[4] = 16'h4BF1;

      // Reset values
      repeat (2) tick();
      chk("rst_send_cmd", send_cmd, 0);
      chk("rst_cmd", cmd, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_err_code", err_code, ERR_NONE);
      chk("rst_bad_resp", bad_resp, 0);
      chk("rst_pass_cnt", pass_cnt, 0);
      chk("rst_full", full, 0);
      chk("rst_empty", empty, 1);
      chk("rst_state", dbg_state, IDLE);
      rst_n = 1'b1;
      tick();

      // start on an empty queue is ignored
      do_start();
      chk("start_empty_busy", busy, 0);
      chk("start_empty_send", send_cmd, 0);

      // Single command
      push_cmd({CMD_MOVE, 12'h001}, 1'b1);
      do_start();
      serve_one(ACK_BYTE, 1'b0);
      chk("single_done", done, 1);
      tick();
      chk("single_done_once", done, 0);
      chk("single_pass_cnt", pass_cnt, 1);
      chk("single_err", err, 0);
      chk("single_busy_off", busy, 0);
      chk("single_empty", empty, 1);

      // Five commands, all acked; serve_one checks ack->send latency of 1
      for (int i = 0; i < 5; i++) push_cmd(five[i], 1'b1);
      do_start();
      for (int i = 0; i < 5; i++) begin
         serve_one(ACK_BYTE, 1'b0);
         if (i < 4) chk("five_no_early_done", done, 0);
      end
      chk("five_done", done, 1);
      tick();
      chk("five_done_once", done, 0);
      chk("five_pass_cnt", pass_cnt, 5);
      chk("five_empty", empty, 1);

      // Bad response on the second command
      for (int i = 0; i < 5; i++) push_cmd(five[i], 1'b1);
      do_start();
      serve_one(ACK_BYTE, 1'b0);
      serve_one(8'h5A, 1'b0);
      chk("bad_err", err, 1);
      chk("bad_err_code", err_code, ERR_BADRESP);
      chk("bad_resp_byte", bad_resp, 8'h5A);
      chk("bad_pass_cnt", pass_cnt, 1);
      chk("bad_busy", busy, 0);
      chk("bad_state", dbg_state, ERR);
      chk("bad_queue_kept", empty, 0);
      push_cmd({CMD_TOUR, 12'h123}, 1'b0);
      repeat (3) begin
         tick();
         chk("bad_no_send", send_cmd, 0);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_err", err, 0);
      chk("abort_err_code", err_code, ERR_NONE);
      chk("abort_bad_resp", bad_resp, 0);
      chk("abort_empty", empty, 1);
      chk("abort_state", dbg_state, IDLE);
      chk("abort_pass_hold", pass_cnt, 1);
      exp_q.delete();

      // Timeout: ISSUE is cycle 0, ERR expected in cycle TMO
      push_cmd(16'h4002, 1'b1);
      do_start();
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
      chk("tmo_send", send_cmd, 1);
      chk("tmo_cmd", cmd, e);
      tick();
      cmd_sent = 1'b1;
      tick();
      cmd_sent = 1'b0;
      repeat (TMO - 3) tick();
      chk("tmo_not_early", err, 0);
      chk("tmo_wait_state", dbg_state, WAIT_RESP);
      tick();
`ifdef CMD_SEQ_TIMEOUT_EN
      chk("tmo_err", err, 1);
      chk("tmo_err_code", err_code, ERR_TIMEOUT);
      chk("tmo_state", dbg_state, ERR);
`else
      chk("notmo_err", err, 0);
      chk("notmo_state", dbg_state, WAIT_RESP);
`endif
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("tmo_abort_state", dbg_state, IDLE);
      chk("tmo_abort_err", err, 0);
      chk("tmo_abort_empty", empty, 1);

      // Fill past DEPTH; push while full in the ISSUE (pop) cycle is dropped
      for (int i = 0; i < DEPTH + 1; i++) begin
         push_cmd(16'h4100 + 16'(i), (i < DEPTH));
         if (i == DEPTH - 2) chk("not_full_yet", full, 0);
      end
      chk("full_after_fill", full, 1);
      chk("full_not_empty", empty, 0);
      do_start();
      cmd_in = 16'hBEEF;
      push   = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         serve_one(ACK_BYTE, (i == 0));
         if (i == 0) chk("push_full_dropped", full, 0);
      end
      chk("fill_done", done, 1);
      tick();
      chk("fill_pass_cnt", pass_cnt, DEPTH);
      chk("fill_empty", empty, 1);
      chk("fill_no_extra_send", send_cmd, 0);

      // Reset asserted in WAIT_SENT
      push_cmd(16'h4777, 1'b1);
      do_start();
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
      chk("rstmid_cmd", cmd, e);
      tick();
      chk("rstmid_wait_sent", dbg_state, WAIT_SENT);
      #2 rst_n = 1'b0;
      #1;
      chk("rstmid_state", dbg_state, IDLE);
      chk("rstmid_send", send_cmd, 0);
      chk("rstmid_cmd_clr", cmd, 0);
      chk("rstmid_busy", busy, 0);
      chk("rstmid_empty", empty, 1);
      chk("rstmid_pass", pass_cnt, 0);
      #2 rst_n = 1'b1;
      cmd_sent = 1'b1;
      tick();
      cmd_sent = 1'b0;
      repeat (3) begin
         tick();
         chk("rstmid_no_send", send_cmd, 0);
      end

      // Abort in WAIT_RESP, coinciding with an ack rise
      push_cmd(16'h4888, 1'b1);
      push_cmd(16'h4999, 1'b0);
      do_start();
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
      chk("abt_send", send_cmd, 1);
      chk("abt_cmd", cmd, e);
      tick();
      cmd_sent = 1'b1;
      tick();
      cmd_sent = 1'b0;
      chk("abt_wait_resp", dbg_state, WAIT_RESP);
      abort    = 1'b1;
      resp     = ACK_BYTE;
      resp_rdy = 1'b1;
      tick();
      abort    = 1'b0;
      resp_rdy = 1'b0;
      chk("abt_state", dbg_state, IDLE);
      chk("abt_busy", busy, 0);
      chk("abt_send_off", send_cmd, 0);
      chk("abt_empty", empty, 1);
      chk("abt_pass_hold", pass_cnt, 0);
      repeat (3) begin
         tick();
         chk("abt_no_send", send_cmd, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
